// File: rtl/xfer_samples.sv
// Sample-time transfer stage: pops one L1A-sample header, then moves NCHAN channel words
// into the event buffer tagged with readout-window overlap and end-of-event status.
module xfer_samples #(
  parameter int NCHAN = 16,
  parameter int NWIN  = 4
) (
  input  logic        WCLK,
  input  logic        RST_RESYNC,
  input  logic [6:0]  SAMP_MAX,
  input  logic        SMP_MT,
  input  logic [11:0] SMP_DATA,
  output logic        SMP_RD,
  input  logic        L1S_MT,
  input  logic [37:0] L1S_DATA,
  output logic        L1S_RD,
  output logic [11:0] WDATA,
  output logic        WREN,
  output logic [6:0]  OVRLP_EVT_DATA,
  output logic [37:0] L1A_EVT_DATA,
  output logic        L1A_WRT_EN,
  output logic        WIN_OVF,
  output logic        BUSY
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [CW-1:0] LAST_CHAN = CW'(NCHAN - 1);

  typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;
  state_t state, next_state;

  logic [CW-1:0]   chan;
  logic [NWIN-1:0] slot_act;
  logic [6:0]      slot_cnt [NWIN];
  logic [3:0]      ocnt;
  logic            ovrlp;
  logic            movlp;
  logic            win_end;
  logic [NWIN-1:0] load_sel;
  logic            slot_found;
  logic [3:0]      hdr_ocnt;
  logic            hdr_end;
  logic            l1s_match;
  logic            last_rd;

  assign l1s_match = L1S_DATA[36];
  assign last_rd   = SMP_RD && (chan == LAST_CHAN);

  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) state <= IDLE;
    else            state <= next_state;
  end

  // Read strobes are gated by the live empty flags so a FWFT FIFO that just drained is never over-read.
  always_comb begin
    next_state = state;
    SMP_RD     = 1'b0;
    L1S_RD     = 1'b0;
    case (state)
      IDLE: if (!L1S_MT) next_state = HDR;
      HDR: begin
        L1S_RD     = 1'b1;
        next_state = XFER;
      end
      XFER: begin
        if (!SMP_MT) begin
          SMP_RD = 1'b1;
          if (chan == LAST_CHAN) next_state = L1S_MT ? IDLE : HDR;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_sel   = '0;
    slot_found = 1'b0;
    hdr_ocnt   = '0;
    hdr_end    = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      if (l1s_match && !slot_act[i] && !slot_found) begin
        load_sel[i] = 1'b1;
        slot_found  = 1'b1;
      end
    end
    // A slot opened this sample counts toward the overlap and may itself end here when SAMP_MAX is 0.
    for (int i = 0; i < NWIN; i++) begin
      if (slot_act[i] || load_sel[i]) begin
        hdr_ocnt = hdr_ocnt + 4'd1;
        if ((load_sel[i] ? SAMP_MAX : slot_cnt[i]) == 7'd0) hdr_end = 1'b1;
      end
    end
  end

  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      chan           <= '0;
      slot_act       <= '0;
      for (int i = 0; i < NWIN; i++) slot_cnt[i] <= '0;
      ocnt           <= '0;
      ovrlp          <= 1'b0;
      movlp          <= 1'b0;
      win_end        <= 1'b0;
      WDATA          <= '0;
      WREN           <= 1'b0;
      OVRLP_EVT_DATA <= '0;
      L1A_EVT_DATA   <= '0;
      L1A_WRT_EN     <= 1'b0;
      WIN_OVF        <= 1'b0;
      BUSY           <= 1'b0;
    end else begin
      WREN       <= 1'b0;
      L1A_WRT_EN <= 1'b0;
      BUSY       <= (next_state != IDLE);
      if (state == HDR) begin
        L1A_EVT_DATA <= L1S_DATA;
        L1A_WRT_EN   <= 1'b1;
        chan         <= '0;
        ocnt         <= hdr_ocnt;
        ovrlp        <= (hdr_ocnt > 4'd1);
        movlp        <= (hdr_ocnt > 4'd2);
        win_end      <= hdr_end;
        if (l1s_match && !slot_found) WIN_OVF <= 1'b1;
        for (int i = 0; i < NWIN; i++) begin
          if (load_sel[i]) begin
            slot_act[i] <= 1'b1;
            slot_cnt[i] <= SAMP_MAX;
          end
        end
      end
      if (SMP_RD) begin
        chan           <= chan + 1'b1;
        WDATA          <= SMP_DATA;
        WREN           <= (ocnt != 4'd0);
        OVRLP_EVT_DATA <= {win_end && (chan == LAST_CHAN), movlp, ovrlp, ocnt};
        // Windows age only once the whole sample time has been read.
        if (last_rd) begin
          for (int i = 0; i < NWIN; i++) begin
            if (slot_act[i]) begin
              if (slot_cnt[i] == 7'd0) slot_act[i] <= 1'b0;
              else                     slot_cnt[i] <= slot_cnt[i] - 7'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xfer_samples.sv
// Scoreboard bench for xfer_samples: FIFO models feed the DUT, a window-list reference
// model predicts every word and L1A record, and a monitor compares them as they appear.
module tb_xfer_samples;

  localparam int NCHAN = 16;
  localparam int NWIN  = 4;

  logic        WCLK = 1'b0;
  logic        RST_RESYNC;
  logic [6:0]  SAMP_MAX;
  logic        SMP_MT;
  logic [11:0] SMP_DATA;
  logic        SMP_RD;
  logic        L1S_MT;
  logic [37:0] L1S_DATA;
  logic        L1S_RD;
  logic [11:0] WDATA;
  logic        WREN;
  logic [6:0]  OVRLP_EVT_DATA;
  logic [37:0] L1A_EVT_DATA;
  logic        L1A_WRT_EN;
  logic        WIN_OVF;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int wren_cnt = 0;
  int end_cnt = 0;
  int l1a_cnt = 0;
  int rd_cnt = 0;

  logic [11:0] smp_q [$];
  logic [37:0] l1s_q [$];
  logic [18:0] exp_w_q [$];
  logic [37:0] exp_l1a_q [$];
  logic        stall = 1'b0;

  int   win [$];
  logic exp_ovf = 1'b0;

  always #5 WCLK = ~WCLK;

  xfer_samples #(.NCHAN(NCHAN), .NWIN(NWIN)) dut (
    .WCLK(WCLK), .RST_RESYNC(RST_RESYNC), .SAMP_MAX(SAMP_MAX),
    .SMP_MT(SMP_MT), .SMP_DATA(SMP_DATA), .SMP_RD(SMP_RD),
    .L1S_MT(L1S_MT), .L1S_DATA(L1S_DATA), .L1S_RD(L1S_RD),
    .WDATA(WDATA), .WREN(WREN), .OVRLP_EVT_DATA(OVRLP_EVT_DATA),
    .L1A_EVT_DATA(L1A_EVT_DATA), .L1A_WRT_EN(L1A_WRT_EN),
    .WIN_OVF(WIN_OVF), .BUSY(BUSY)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FWFT FIFO models: pop on a sampled read strobe, refresh outputs just after the edge.
  initial begin
    logic rs, rl;
    SMP_MT = 1'b1; L1S_MT = 1'b1; SMP_DATA = '0; L1S_DATA = '0;
    forever begin
      @(posedge WCLK);
      rs = SMP_RD;
      rl = L1S_RD;
      #1;
      if (RST_RESYNC) begin
        smp_q.delete();
        l1s_q.delete();
      end else begin
        if (rs && smp_q.size() > 0) void'(smp_q.pop_front());
        if (rl && l1s_q.size() > 0) void'(l1s_q.pop_front());
      end
      SMP_MT   = stall || (smp_q.size() == 0);
      SMP_DATA = (smp_q.size() > 0) ? smp_q[0] : 12'd0;
      L1S_MT   = (l1s_q.size() == 0);
      L1S_DATA = (l1s_q.size() > 0) ? l1s_q[0] : 38'd0;
    end
  end

  // Monitor: compares every presented word / L1A record with the head of the scoreboard.
  initial begin
    logic prev_rd, prev_l1;
    logic [18:0] ew;
    logic [37:0] el;
    prev_rd = 1'b0; prev_l1 = 1'b0;
    forever begin
      @(negedge WCLK);
      if (RST_RESYNC) begin
        exp_w_q.delete();
        exp_l1a_q.delete();
        prev_rd = 1'b0; prev_l1 = 1'b0;
      end else begin
        if (SMP_RD) begin
          rd_cnt++;
          checkOutput("smp_rd_while_mt", 64'(SMP_MT), 64'd0);
        end
        if (L1S_RD) checkOutput("l1s_rd_while_mt", 64'(L1S_MT), 64'd0);
        if (WREN) begin
          wren_cnt++;
          if (OVRLP_EVT_DATA[6]) end_cnt++;
          checkOutput("wren_latency", 64'(prev_rd), 64'd1);
          if (exp_w_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_word: actual=0x%0h required=none at %0t", {WDATA, OVRLP_EVT_DATA}, $time);
          end else begin
            ew = exp_w_q.pop_front();
            checkOutput("word", 64'({WDATA, OVRLP_EVT_DATA}), 64'(ew));
          end
        end
        if (L1A_WRT_EN) begin
          l1a_cnt++;
          checkOutput("l1a_latency", 64'(prev_l1), 64'd1);
          if (exp_l1a_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_l1a: actual=0x%0h required=none at %0t", L1A_EVT_DATA, $time);
          end else begin
            el = exp_l1a_q.pop_front();
            checkOutput("l1a_data", 64'(L1A_EVT_DATA), 64'(el));
          end
        end
        prev_rd = SMP_RD;
        prev_l1 = L1S_RD;
      end
    end
  end

  // Queue nsamp sample times; bit s of mask marks an L1A match on sample s.
  task automatic applyStimulus(input int nsamp, input logic [63:0] mask);
    for (int s = 0; s < nsamp; s++) begin
      logic [37:0] hdr;
      logic [11:0] d;
      int ocnt;
      logic endf;
      int nw [$];
      nw.delete();
      hdr = {1'($urandom), mask[s], 12'($urandom), 24'($urandom)};
      l1s_q.push_back(hdr);
      exp_l1a_q.push_back(hdr);
      if (mask[s]) begin
        if (win.size() < NWIN) win.push_back(int'(SAMP_MAX));
        else exp_ovf = 1'b1;
      end
      ocnt = win.size();
      endf = 1'b0;
      foreach (win[i]) if (win[i] == 0) endf = 1'b1;
      for (int c = 0; c < NCHAN; c++) begin
        d = 12'($urandom);
        smp_q.push_back(d);
        if (ocnt > 0)
          exp_w_q.push_back({d, endf && (c == NCHAN - 1), ocnt > 2, ocnt > 1, 4'(ocnt)});
      end
      foreach (win[i]) if (win[i] != 0) nw.push_back(win[i] - 1);
      win = nw;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (n < 5000 && !(smp_q.size() == 0 && l1s_q.size() == 0 && exp_w_q.size() == 0 &&
                         exp_l1a_q.size() == 0 && BUSY == 1'b0)) begin
      @(negedge WCLK);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout: actual=%0d cycles required<5000", name, n);
    end
    repeat (2) @(negedge WCLK);
  endtask

  task automatic waitReads(input string name, input int target);
    int n = 0;
    while (rd_cnt < target && n < 5000) begin
      @(negedge WCLK);
      #1;
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout: actual=%0d reads required=%0d", name, rd_cnt, target);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_smp_rd"}, 64'(SMP_RD), 64'd0);
    checkOutput({tag, "_l1s_rd"}, 64'(L1S_RD), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(WDATA), 64'd0);
    checkOutput({tag, "_wren"}, 64'(WREN), 64'd0);
    checkOutput({tag, "_ovrlp_data"}, 64'(OVRLP_EVT_DATA), 64'd0);
    checkOutput({tag, "_l1a_data"}, 64'(L1A_EVT_DATA), 64'd0);
    checkOutput({tag, "_l1a_en"}, 64'(L1A_WRT_EN), 64'd0);
    checkOutput({tag, "_win_ovf"}, 64'(WIN_OVF), 64'd0);
    checkOutput({tag, "_busy"}, 64'(BUSY), 64'd0);
  endtask

  task automatic runCounted(input string name, input int nsamp, input logic [63:0] mask,
                            input int exp_words, input int exp_ends);
    int bw, be, bl;
    bw = wren_cnt; be = end_cnt; bl = l1a_cnt;
    applyStimulus(nsamp, mask);
    waitDrain(name);
    checkOutput({name, "_wren_count"}, 64'(wren_cnt - bw), 64'(exp_words));
    checkOutput({name, "_end_count"}, 64'(end_cnt - be), 64'(exp_ends));
    checkOutput({name, "_l1a_count"}, 64'(l1a_cnt - bl), 64'(nsamp));
    checkOutput({name, "_win_ovf"}, 64'(WIN_OVF), 64'(exp_ovf));
  endtask

  initial begin
    logic [63:0] rmask;
    int bw, be;
    RST_RESYNC = 1'b1;
    SAMP_MAX   = 7'd0;
    #2;
    checkAllZero("reset");
    repeat (3) @(negedge WCLK);
    RST_RESYNC = 1'b0;
    repeat (2) @(negedge WCLK);

    $display("[TB] single window");
    SAMP_MAX = 7'd5;
    runCounted("single", 8, 64'h1, 96, 1);

    $display("[TB] double overlap");
    runCounted("overlap", 9, 64'h9, 144, 2);

    $display("[TB] triple overlap");
    SAMP_MAX = 7'd7;
    runCounted("triple", 10, 64'h7, 160, 3);

    $display("[TB] one-sample windows");
    SAMP_MAX = 7'd0;
    runCounted("samp0", 3, 64'h5, 32, 2);

    $display("[TB] slot exhaustion");
    SAMP_MAX = 7'd15;
    runCounted("exhaust", 19, 64'h1F, 304, 4);
    checkOutput("exhaust_ovf_set", 64'(WIN_OVF), 64'd1);

    $display("[TB] stall mid-sample");
    SAMP_MAX = 7'd5;
    bw = wren_cnt; be = end_cnt;
    applyStimulus(6, 64'h1);
    waitReads("stall", rd_cnt + 2 * NCHAN + 7);
    stall = 1'b1;
    @(negedge WCLK);
    repeat (10) begin
      @(negedge WCLK);
      checkOutput("stall_smp_rd", 64'(SMP_RD), 64'd0);
      checkOutput("stall_wren", 64'(WREN), 64'd0);
    end
    stall = 1'b0;
    waitDrain("stall");
    checkOutput("stall_wren_count", 64'(wren_cnt - bw), 64'd96);
    checkOutput("stall_end_count", 64'(end_cnt - be), 64'd1);

    $display("[TB] reset mid-transfer");
    SAMP_MAX = 7'd3;
    applyStimulus(4, 64'h1);
    waitReads("reset_mid", rd_cnt + NCHAN + 4);
    #1 RST_RESYNC = 1'b1;
    #1 checkAllZero("async_reset");
    repeat (3) @(posedge WCLK);
    @(negedge WCLK);
    checkOutput("reset_idle_busy", 64'(BUSY), 64'd0);
    win.delete();
    exp_ovf = 1'b0;
    RST_RESYNC = 1'b0;
    repeat (2) @(negedge WCLK);
    runCounted("post_reset", 5, 64'h1, 64, 1);

    $display("[TB] randomized windows");
    for (int r = 0; r < 4; r++) begin
      SAMP_MAX = 7'($urandom_range(0, 6));
      rmask = '0;
      for (int s = 0; s < 20; s++) rmask[s] = ($urandom_range(0, 2) == 0);
      applyStimulus(20, rmask);
      waitDrain("random");
      checkOutput("random_win_ovf", 64'(WIN_OVF), 64'(exp_ovf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
